// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types for the round-robin grant arbiter: FSM state encoding,
// requester count and the owner-index type.
package rr_grant_arbiter_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   typedef logic [1:0] owner_t;

endpackage : rr_grant_arbiter_pkg

// File: rtl/rr_grant_arbiter_onehot_dec2.sv
// 2-to-4 one-hot decoder; output is all zeros while en is low.
module onehot_dec2
   import rr_grant_arbiter_pkg::*;
(
   input  owner_t          idx,
   input  logic            en,
   output logic [NREQ-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule : onehot_dec2

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter with grant lock and a hold limit that
// pre-empts an owner once it has held MAX_HOLD cycles while others wait.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; first request found from ptr wins next cycle
// ST_GRANT | gnt_id owns the resource until release or hold timeout
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int NREQ_P   = 4,
   parameter int MAX_HOLD = 16,
   parameter int CNTW     = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output owner_t          gnt_id,
   output logic            gnt_vld,
   output logic            timeout
);

   localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);

   state_t          state_q, state_nxt;
   owner_t          ptr, ptr_nxt;
   owner_t          id_nxt;
   logic            vld_nxt;
   logic            to_nxt;
   logic [CNTW-1:0] hold_cnt, hold_nxt;
   logic [NREQ-1:0] others;
   owner_t          k_next;
   logic [2:0]      pick;

   // Returns {found, index}: first set bit of v from start upward, wrapping.
   // Iterating downward lets the lowest offset overwrite the others.
   function automatic logic [2:0] rr_search(input logic [NREQ-1:0] v, input owner_t start);
      logic [2:0] r;
      owner_t     idx;
      r = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = start + owner_t'(i);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   always_comb begin
      state_nxt = state_q;
      ptr_nxt   = ptr;
      id_nxt    = gnt_id;
      vld_nxt   = gnt_vld;
      to_nxt    = 1'b0;
      hold_nxt  = hold_cnt;
      others    = req;
      others[gnt_id] = 1'b0;
      k_next    = gnt_id + 2'd1;
      pick      = '0;

      case (state_q)
         ST_IDLE: begin
            pick = rr_search(req, ptr);
            if (pick[2]) begin
               id_nxt    = pick[1:0];
               vld_nxt   = 1'b1;
               hold_nxt  = '0;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!req[gnt_id]) begin
               ptr_nxt  = k_next;
               hold_nxt = '0;
               pick     = rr_search(req, k_next);
               if (pick[2]) begin
                  id_nxt = pick[1:0];
               end else begin
                  vld_nxt   = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (others != '0)) begin
               pick     = rr_search(others, k_next);
               id_nxt   = pick[1:0];
               ptr_nxt  = k_next;
               to_nxt   = 1'b1;
               hold_nxt = '0;
            end else if (hold_cnt != HOLD_LAST) begin
               // Saturating, so a lone holder is pre-empted as soon as anyone asks.
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr      <= '0;
         gnt_id   <= '0;
         gnt_vld  <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state_q  <= state_nxt;
         ptr      <= ptr_nxt;
         gnt_id   <= id_nxt;
         gnt_vld  <= vld_nxt;
         timeout  <= to_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   onehot_dec2 u_dec (
      .idx    (gnt_id),
      .en     (gnt_vld),
      .onehot (gnt)
   );

endmodule : rr_grant_arbiter

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter (MAX_HOLD=4): directed scenarios plus a
// randomized run against a cycle-level ownership model.
module tb_rr_grant_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;
   logic       timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // model: owner (-1 = none), search pointer, cycles held so far
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_to    = 0;

   rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNTW(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   function automatic int find_first(input logic [3:0] v, input int start);
      for (int i = 0; i < 4; i++)
         if (v[(start + i) % 4]) return (start + i) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      logic [3:0] oth;
      m_to = 0;
      if (m_owner < 0) begin
         if (r != 0) begin m_owner = find_first(r, m_ptr); m_held = 1; end
      end else if (!r[m_owner]) begin
         m_ptr   = (m_owner + 1) % 4;
         m_owner = find_first(r, m_ptr);
         m_held  = 1;
      end else begin
         oth = r & ~(4'b1 << m_owner);
         if (MAX_HOLD > 0 && m_held >= MAX_HOLD && oth != 0) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = find_first(oth, m_ptr);
            m_held  = 1;
            m_to    = 1;
         end else begin
            m_held++;
         end
      end
   endtask

   function automatic logic [3:0] model_gnt();
      return (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(req);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (gnt !== 4'b0 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: gnt=%b vld=%b id=%0d to=%b, want 0000/0/0/0", gnt, gnt_vld, gnt_id, timeout);
      end
      req = 4'b0001;
      tick();
      n_tests++;
      if (gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_pre_grant: gnt=%b want 0001", gnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (gnt !== 4'b0 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: gnt=%b vld=%b to=%b, want 0000/0/0", gnt, gnt_vld, timeout);
      end
      model_reset();
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      tick();
      n_tests++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: gnt=%b id=%0d vld=%b, want 0100/2/1", gnt, gnt_id, gnt_vld);
      end
      req = 4'b0000;
      tick();
      n_tests++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: gnt=%b vld=%b, want 0000/0", gnt, gnt_vld);
      end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111;
      tick();
      for (int j = 0; j < 5; j++) begin
         n_tests++;
         if (gnt !== (4'b1 << order[j]) || gnt_vld !== 1'b1 || gnt_id !== 2'(order[j])) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: gnt=%b vld=%b id=%0d, want owner %0d", j, gnt, gnt_vld, gnt_id, order[j]);
         end
         req = 4'b1111 & ~(4'b1 << order[j]);
         tick();
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= 9; c++) begin
         logic [3:0] eg;
         logic       et;
         tick();
         eg = (c <= 4 || c == 9) ? 4'b0001 : 4'b0010;
         et = (c == 5 || c == 9);
         n_tests++;
         if (gnt !== eg || timeout !== et) begin
            n_fail++;
            $display("FAIL timeout_cycle%0d: gnt=%b to=%b, want %b/%b", c, gnt, timeout, eg, et);
         end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_lone_holder();
      int bad = 0;
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL lone_holder: %0d bad cycles, want gnt=0001 to=0 for all 20", bad);
      end
      // a long-standing holder is pre-empted as soon as someone else asks
      req = 4'b0011;
      tick();
      n_tests++;
      if (gnt !== 4'b0010 || timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL lone_preempt: gnt=%b to=%b, want 0010/1", gnt, timeout);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_collision();
      do_reset();
      req = 4'b0011;
      tick();
      req = 4'b0010;
      tick();
      n_tests++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL collision_setup: gnt=%b want 0010", gnt);
      end
      req = 4'b1001;
      tick();
      n_tests++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_grant: gnt=%b id=%0d to=%b, want 1000/3/0", gnt, gnt_id, timeout);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      logic [3:0] eg;
      int         b;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            req = 4'($urandom);
         end else if ($urandom_range(0, 2) == 0) begin
            b = $urandom_range(0, 3);
            req[b] = ~req[b];
         end
         tick();
         eg = model_gnt();
         n_tests++;
         if (gnt !== eg || gnt_vld !== (m_owner >= 0) || timeout !== m_to) begin
            n_fail++;
            $display("FAIL random_c%0d: req=%b gnt=%b vld=%b to=%b, want %b/%b/%b",
                     c, req, gnt, gnt_vld, timeout, eg, (m_owner >= 0), m_to);
         end
         if (m_owner >= 0) begin
            n_tests++;
            if (gnt_id !== 2'(m_owner)) begin
               n_fail++;
               $display("FAIL random_id_c%0d: gnt_id=%0d want %0d", c, gnt_id, m_owner);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_lone_holder();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rr_grant_arbiter
